// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and default operand width shared by the
// serial_adder block.
package serial_adder_pkg;

   localparam int SA_DEFAULT_WIDTH = 8;

   localparam logic [1:0] SA_IDLE = 2'd0;
   localparam logic [1:0] SA_RUN  = 2'd1;
   localparam logic [1:0] SA_DONE = 2'd2;

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: combinational one-bit full adder built from XOR/AND/OR gates.
// SA_GATE_DLY is the codebase gate-delay macro; it is empty unless a gate-level
// timing build defines it (for example as #1).
`ifndef SA_GATE_DLY
`define SA_GATE_DLY
`endif

module serial_fa_cell
   import serial_adder_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic axb;
   logic a_and_b;
   logic c_and_axb;

   assign `SA_GATE_DLY axb       = a ^ b;
   assign `SA_GATE_DLY sum       = axb ^ cin;
   assign `SA_GATE_DLY a_and_b   = a & b;
   assign `SA_GATE_DLY c_and_axb = cin & axb;
   assign `SA_GATE_DLY cout      = a_and_b | c_and_axb;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing {cout,sum} = a + b + cin, one bit per
// clock, LSB first, through a single full-adder cell.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
// done is high during the DONE cycle, so it is sampled high at the (WIDTH+1)th
// rising edge after the accepting edge.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = SA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             done
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic fa_sum;
   logic fa_cout;

   serial_fa_cell u_fa (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   assign ready = (state_q != SA_RUN);
   assign done  = (state_q == SA_DONE);
   assign sum   = sum_q;
   assign cout  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

   // Next-state logic: load on an accepted start, one serial bit per RUN cycle.
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         SA_IDLE, SA_DONE: begin
            if (start) begin
               // Accepting edge: capture operands and clear the previous result.
               state_d = SA_RUN;
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end else begin
               state_d = SA_IDLE;
            end
         end
         SA_RUN: begin
            // Sum bits enter at the MSB so bit 0 ends at sum[0] after WIDTH shifts.
            sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
            carry_d = fa_cout;
            a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = SA_DONE;
               cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB during the final bit.
               ovf_d   = carry_q ^ fa_cout;
`endif
            end
         end
         default: state_d = SA_IDLE;
      endcase
   end

   // State and datapath registers; reset clears everything and beats start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SA_IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

endmodule
